// File: rtl/ft601_rx_reader_if.sv
// FT601 245-mode receive pads plus the captured-word stream, viewed from the reader (master).
// No state of its own; the stream side uses valid/ready with pop on m_valid && m_ready.
// The reader never drives FT_DATA/BE, so bus_oe is constant low.
interface ft601_rx_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  RXF_N;
    logic [31:0]           ft_data_in;
    logic [3:0]            ft_be_in;
    logic                  OE_N;
    logic                  RD_N;
    logic                  bus_oe;
    logic [DATA_WIDTH-1:0] m_data;
    logic [3:0]            m_be;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  RXF_N, ft_data_in, ft_be_in, m_ready,
        output OE_N, RD_N, bus_oe, m_data, m_be, m_valid
    );

    modport slave (
        output RXF_N, ft_data_in, ft_be_in, m_ready,
        input  OE_N, RD_N, bus_oe, m_data, m_be, m_valid
    );
endinterface

// File: rtl/ft601_rx_reader.sv
// FT601 host-to-FPGA read master: OE_N/RD_N bursts into a first-word-fall-through FIFO.
// Latency: one turnaround cycle before RD_N; a pushed word appears on m_valid one cycle later.
// Backpressure: m_ready stalls the FIFO; bursts start only with MIN_FREE free entries and stop when full.
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    input  logic                   rd_rdy,
    output logic                   rd_vld,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_fire = wr_vld && (count != FULL_CNT);
    assign rd_fire = rd_rdy && (count != '0);
    assign rd_vld  = (count != '0);
    // Head is masked so the stream bus reads zero while empty.
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            if (wr_fire && !rd_fire) begin
                count <= count + 1'b1;
            end else if (rd_fire && !wr_fire) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module ft601_rx_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int MIN_FREE   = 4
) (
    input  logic        FT_CLK,
    input  logic        rst,
    input  logic        rx_allow,
    output logic        rx_busy,
    output logic [31:0] rx_words,
    output logic        overrun,
    ft601_rx_reader_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = DATA_WIDTH + 4;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_CNT  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] START_CNT = (AW+1)'(DEPTH - MIN_FREE);

    // Bit 0 = OE active, bit 1 = RD active, so each strobe is a single flop.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        TURN = 2'b01,
        READ = 2'b11
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   fifo_cnt;
    logic          push_try;
    logic          push_vld;
    logic          pop_fire;
    logic          fill_last;
    logic [FW-1:0] push_dat;
    logic [FW-1:0] head_dat;
    logic          unused_bits;

    assign push_try  = (state == READ) && !bus.RXF_N;
    assign push_vld  = push_try && (fifo_cnt != FULL_CNT);
    assign pop_fire  = bus.m_valid && bus.m_ready;
    assign fill_last = push_vld && !pop_fire && (fifo_cnt == LAST_CNT);
    assign push_dat  = {bus.ft_be_in, bus.ft_data_in[DATA_WIDTH-1:0]};
    assign unused_bits = ^bus.ft_data_in;

    always_ff @(posedge FT_CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!bus.RXF_N && rx_allow && (fifo_cnt <= START_CNT)) state_nxt = TURN;
            TURN: state_nxt = READ;
            READ: if (bus.RXF_N || fill_last || (fifo_cnt == FULL_CNT)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.OE_N   = ~state[0];
        bus.RD_N   = ~state[1];
        bus.bus_oe = 1'b0;
        rx_busy    = state[0];
    end

    always_ff @(posedge FT_CLK or posedge rst) begin
        if (rst) begin
            rx_words <= '0;
            overrun  <= 1'b0;
        end else begin
            if (push_vld) rx_words <= rx_words + 32'd1;
            if (push_try && (fifo_cnt == FULL_CNT)) overrun <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (FT_CLK),
        .rst    (rst),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .rd_rdy (bus.m_ready),
        .rd_vld (bus.m_valid),
        .rd_dat (head_dat),
        .count  (fifo_cnt)
    );

    assign {bus.m_be, bus.m_data} = head_dat;
endmodule
